// File: rtl/pixel_pair_sequencer.sv
// pixel_pair_sequencer
// Walks a frame of WIDTH x HEIGHT pixels stored as pixel pairs in an
// external pair memory. Each pair is fetched, waited on for the one-cycle
// read latency, then presented on DATA_WRITE_* for a single hsync cycle.
// Build option: define LINE_BLANK_EN to insert LINE_GAP blanking cycles
// after every row except the last; without it rows run back to back.

module pixel_pair_sequencer #(
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 8,
    parameter int LINE_GAP = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        stall,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [47:0] mem_rdata,
    output logic        hsync,
    output logic [7:0]  DATA_WRITE_R0,
    output logic [7:0]  DATA_WRITE_G0,
    output logic [7:0]  DATA_WRITE_B0,
    output logic [7:0]  DATA_WRITE_R1,
    output logic [7:0]  DATA_WRITE_G1,
    output logic [7:0]  DATA_WRITE_B1,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frame_count
);

    // Frame geometry in pairs, and counter widths that stay legal for
    // degenerate sizes (a single pair, a single pair per row, one gap cycle).
    localparam int TOTAL = (WIDTH * HEIGHT) / 2;
    localparam int ROWP  = WIDTH / 2;
    localparam int PW    = (TOTAL > 1)    ? $clog2(TOTAL)    : 1;
    localparam int CW    = (ROWP > 1)     ? $clog2(ROWP)     : 1;
    localparam int BW    = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [PW-1:0] LAST_PAIR = PW'(TOTAL - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(ROWP - 1);
    localparam logic [BW-1:0] LAST_GAP  = BW'(LINE_GAP - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_BLANK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q,     state_d;
    logic [PW-1:0] pair_cnt_q,  pair_cnt_d;
    logic [CW-1:0] col_cnt_q,   col_cnt_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic          hsync_q,     hsync_d;
    logic          done_q,      done_d;
    logic          busy_q,      busy_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [47:0]   data_q;
    logic          capture;

    // Next-state and counter update for the frame walk.
    always_comb begin
        state_d     = state_q;
        pair_cnt_d  = pair_cnt_q;
        col_cnt_d   = col_cnt_q;
        blank_cnt_d = blank_cnt_q;
        frame_cnt_d = frame_cnt_q;
        hsync_d     = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pair_cnt_d = '0;
                    col_cnt_d  = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                // The read is only issued once downstream is ready, so
                // every stalled cycle simply repeats FETCH.
                if (!stall) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Read data lands this cycle; it is captured on this edge
                // and shown during EMIT.
                state_d = S_EMIT;
                hsync_d = 1'b1;
            end
            S_EMIT: begin
                pair_cnt_d = pair_cnt_q + 1'b1;
                col_cnt_d  = (col_cnt_q == LAST_COL) ? '0 : col_cnt_q + 1'b1;
                // Last-pair test comes first so the final row never blanks.
                if (pair_cnt_q == LAST_PAIR) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
`ifdef LINE_BLANK_EN
                else if (col_cnt_q == LAST_COL) begin
                    state_d     = S_BLANK;
                    blank_cnt_d = '0;
                end
`endif
                else begin
                    state_d = S_FETCH;
                end
            end
            S_BLANK: begin
                // Fixed-length line gap; stall has no effect here.
                if (blank_cnt_q == LAST_GAP) begin
                    blank_cnt_d = '0;
                    state_d     = S_FETCH;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Always return to IDLE: a start seen here is dropped.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Control registers: FSM state, counters and the registered strobes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            pair_cnt_q  <= '0;
            col_cnt_q   <= '0;
            blank_cnt_q <= '0;
            hsync_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            pair_cnt_q  <= pair_cnt_d;
            col_cnt_q   <= col_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            hsync_q     <= hsync_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign capture = (state_q == S_WAIT);

    // Pixel-pair holding register, reloaded only on the edge leaving WAIT.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_q <= 48'h0;
        end else if (capture) begin
            data_q <= mem_rdata;
        end
    end

    // The read strobe follows stall combinationally so a stalled FETCH
    // never issues a read; the address is parked at zero outside FETCH.
    assign mem_rd_en = (state_q == S_FETCH) && !stall;
    assign mem_addr  = (state_q == S_FETCH) ? 16'(pair_cnt_q) : 16'h0;

    assign hsync         = hsync_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign frame_count   = frame_cnt_q;
    assign DATA_WRITE_R0 = data_q[47:40];
    assign DATA_WRITE_G0 = data_q[39:32];
    assign DATA_WRITE_B0 = data_q[31:24];
    assign DATA_WRITE_R1 = data_q[23:16];
    assign DATA_WRITE_G1 = data_q[15:8];
    assign DATA_WRITE_B1 = data_q[7:0];

endmodule

// File: tb/tb_pixel_pair_sequencer.sv
// Directed testbench for pixel_pair_sequencer at default geometry
// (8x8 pixels, 32 pairs, 4 pairs per row, LINE_GAP = 2).

module tb_pixel_pair_sequencer;

    localparam int TOTAL    = 32;
    localparam int ROWP     = 4;
    localparam int LINE_GAP = 2;
`ifdef LINE_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
    // done occupies the 111th cycle after the start edge: 32 pairs x 3 + 7 gaps x 2.
    localparam int EXP_DONE_EDGE = 110;
`else
    localparam bit BLANK_ON = 1'b0;
    // done occupies the 97th cycle after the start edge: 32 pairs x 3.
    localparam int EXP_DONE_EDGE = 96;
`endif
    // With start held high: DONE cycle, one IDLE cycle, then the next start edge.
    localparam int FRAME_PERIOD = EXP_DONE_EDGE + 2;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic        stall;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [47:0] mem_rdata = 48'h0;
    logic        hsync;
    logic [7:0]  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0;
    logic [7:0]  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1;
    logic        busy;
    logic        done;
    logic [7:0]  frame_count;
    logic [47:0] dout;

    int checks   = 0;
    int failures = 0;

    // Per-frame observations gathered by run_frame.
    int          st_hs, st_done_edge, st_fetches;
    int          st_addr_errs, st_data_errs, st_hold_errs, st_gap_errs;
    int          st_busy_errs, st_stall_errs, st_zero_errs;
    logic [47:0] st_sixth;
    logic        st_post_busy, st_post_done;

    pixel_pair_sequencer dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .start         (start),
        .stall         (stall),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .hsync         (hsync),
        .DATA_WRITE_R0 (DATA_WRITE_R0),
        .DATA_WRITE_G0 (DATA_WRITE_G0),
        .DATA_WRITE_B0 (DATA_WRITE_B0),
        .DATA_WRITE_R1 (DATA_WRITE_R1),
        .DATA_WRITE_G1 (DATA_WRITE_G1),
        .DATA_WRITE_B1 (DATA_WRITE_B1),
        .busy          (busy),
        .done          (done),
        .frame_count   (frame_count)
    );

    always #5 HCLK = ~HCLK;

    assign dout = {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
                   DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1};

    // Pair memory contents: address 5 holds the reference pattern.
    function automatic logic [47:0] pat(input int a);
        logic [7:0] b;
        b = a[7:0];
        if (a == 5) return 48'h112233445566;
        return {b, b ^ 8'hFF, b + 8'h40, b + 8'h80, b ^ 8'h5A, 8'hC3};
    endfunction

    // One-cycle read latency memory model.
    always @(posedge HCLK) begin
        if (mem_rd_en) mem_rdata <= pat(int'(mem_addr));
    end

    // Pulse start from IDLE and observe one frame at every falling edge.
    // cyc counts rising edges after the start edge. stall_pair >= 0 holds
    // stall for 4 cycles at that pair's FETCH; abort_after > 0 returns right
    // after that many hsync pulses.
    task automatic run_frame(input int stall_pair, input int abort_after);
        int          cyc, last_hs, stall_left, exp_gap;
        bit          stalled;
        logic [47:0] held;
        st_hs = 0; st_done_edge = -1; st_fetches = 0;
        st_addr_errs = 0; st_data_errs = 0; st_hold_errs = 0; st_gap_errs = 0;
        st_busy_errs = 0; st_stall_errs = 0; st_zero_errs = 0;
        st_sixth = 48'h0; st_post_busy = 1'bx; st_post_done = 1'bx;
        @(negedge HCLK); start = 1'b1;
        @(negedge HCLK); start = 1'b0;
        cyc = 0; last_hs = 0; stall_left = 0; stalled = 1'b0; held = dout;
        while (cyc < 1000) begin
            if (busy !== 1'b1) st_busy_errs++;
            if (hsync === 1'b1) begin
                if (dout !== pat(st_hs)) st_data_errs++;
                if (st_hs == 5) st_sixth = dout;
                if (st_hs == 0) begin
                    if (cyc != 2) st_gap_errs++;
                end else begin
                    exp_gap = 3;
                    if (BLANK_ON && (st_hs % ROWP) == 0) exp_gap += LINE_GAP;
                    if (st_hs == stall_pair) exp_gap += 4;
                    if (cyc - last_hs != exp_gap) st_gap_errs++;
                end
                last_hs = cyc; held = dout; st_hs++;
                if (st_hs == abort_after) return;
            end else if (dout !== held) begin
                st_hold_errs++;
            end
            if (done === 1'b1) begin
                st_done_edge = cyc;
                break;
            end
            if (stall_left > 0) begin
                if (mem_rd_en !== 1'b0 || mem_addr !== 16'(stall_pair)) st_stall_errs++;
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end else if (!stalled && stall_pair >= 0 && mem_rd_en === 1'b1 &&
                         mem_addr === 16'(stall_pair)) begin
                stall = 1'b1; stall_left = 4; stalled = 1'b1;
            end
            #1;
            if (stall_left == 4 && mem_rd_en !== 1'b0) st_stall_errs++;
            if (mem_rd_en === 1'b1) begin
                if (mem_addr !== 16'(st_fetches)) st_addr_errs++;
                st_fetches++;
            end else if (stall === 1'b0 && mem_addr !== 16'h0) begin
                st_zero_errs++;
            end
            @(negedge HCLK); cyc++;
        end
        if (st_done_edge >= 0) begin
            @(negedge HCLK);
            st_post_busy = busy; st_post_done = done;
        end
    endtask

    task automatic test_reset;
        HRESETn = 1'b0; start = 1'b0; stall = 1'b0;
        repeat (3) @(negedge HCLK);
        checks++; if (hsync !== 1'b0) begin failures++; $display("FAIL reset_hsync actual=%b expected=0", hsync); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en actual=%b expected=0", mem_rd_en); end
        checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_addr actual=%h expected=0000", mem_addr); end
        checks++; if (dout !== 48'h0) begin failures++; $display("FAIL reset_data actual=%h expected=000000000000", dout); end
        checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL reset_frame_count actual=%0d expected=0", frame_count); end
        HRESETn = 1'b1;
        repeat (5) @(negedge HCLK);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_without_start busy actual=%b expected=0", busy); end
    endtask

    task automatic test_nominal_frame;
        run_frame(-1, -1);
        checks++; if (st_hs != TOTAL) begin failures++; $display("FAIL nominal_hsync_count actual=%0d expected=%0d", st_hs, TOTAL); end
        checks++; if (st_done_edge != EXP_DONE_EDGE) begin failures++; $display("FAIL nominal_done_edge actual=%0d expected=%0d", st_done_edge, EXP_DONE_EDGE); end
        checks++; if (st_fetches != TOTAL) begin failures++; $display("FAIL nominal_fetch_count actual=%0d expected=%0d", st_fetches, TOTAL); end
        checks++; if (st_addr_errs != 0) begin failures++; $display("FAIL nominal_addr_sequence errors=%0d expected=0", st_addr_errs); end
        checks++; if (st_data_errs != 0) begin failures++; $display("FAIL nominal_pair_data errors=%0d expected=0", st_data_errs); end
        checks++; if (st_hold_errs != 0) begin failures++; $display("FAIL nominal_data_hold errors=%0d expected=0", st_hold_errs); end
        checks++; if (st_gap_errs != 0) begin failures++; $display("FAIL nominal_hsync_spacing errors=%0d expected=0", st_gap_errs); end
        checks++; if (st_busy_errs != 0) begin failures++; $display("FAIL nominal_busy errors=%0d expected=0", st_busy_errs); end
        checks++; if (st_zero_errs != 0) begin failures++; $display("FAIL nominal_addr_zero errors=%0d expected=0", st_zero_errs); end
        checks++; if (st_post_busy !== 1'b0 || st_post_done !== 1'b0) begin failures++; $display("FAIL nominal_after_done busy=%b done=%b expected=0 0", st_post_busy, st_post_done); end
        checks++; if (frame_count !== 8'd1) begin failures++; $display("FAIL nominal_frame_count actual=%0d expected=1", frame_count); end
    endtask

    task automatic test_datapath;
        run_frame(-1, -1);
        checks++; if (st_sixth[47:40] !== 8'h11) begin failures++; $display("FAIL data_R0 actual=%h expected=11", st_sixth[47:40]); end
        checks++; if (st_sixth[39:32] !== 8'h22) begin failures++; $display("FAIL data_G0 actual=%h expected=22", st_sixth[39:32]); end
        checks++; if (st_sixth[31:24] !== 8'h33) begin failures++; $display("FAIL data_B0 actual=%h expected=33", st_sixth[31:24]); end
        checks++; if (st_sixth[23:16] !== 8'h44) begin failures++; $display("FAIL data_R1 actual=%h expected=44", st_sixth[23:16]); end
        checks++; if (st_sixth[15:8] !== 8'h55) begin failures++; $display("FAIL data_G1 actual=%h expected=55", st_sixth[15:8]); end
        checks++; if (st_sixth[7:0] !== 8'h66) begin failures++; $display("FAIL data_B1 actual=%h expected=66", st_sixth[7:0]); end
        checks++; if (frame_count !== 8'd2) begin failures++; $display("FAIL data_frame_count actual=%0d expected=2", frame_count); end
    endtask

    task automatic test_stall;
        run_frame(10, -1);
        checks++; if (st_done_edge != EXP_DONE_EDGE + 4) begin failures++; $display("FAIL stall_done_edge actual=%0d expected=%0d", st_done_edge, EXP_DONE_EDGE + 4); end
        checks++; if (st_stall_errs != 0) begin failures++; $display("FAIL stall_rd_en_held errors=%0d expected=0", st_stall_errs); end
        checks++; if (st_fetches != TOTAL || st_addr_errs != 0) begin failures++; $display("FAIL stall_addr_sequence fetches=%0d errors=%0d expected=%0d 0", st_fetches, st_addr_errs, TOTAL); end
        checks++; if (st_hs != TOTAL || st_data_errs != 0) begin failures++; $display("FAIL stall_pairs hsync=%0d data_errors=%0d expected=%0d 0", st_hs, st_data_errs, TOTAL); end
        checks++; if (st_gap_errs != 0) begin failures++; $display("FAIL stall_hsync_spacing errors=%0d expected=0", st_gap_errs); end
        checks++; if (frame_count !== 8'd3) begin failures++; $display("FAIL stall_frame_count actual=%0d expected=3", frame_count); end
    endtask

    task automatic test_reset_midframe;
        bit saw_activity;
        run_frame(-1, 12);
        checks++; if (st_hs != 12) begin failures++; $display("FAIL midframe_reach_12 actual=%0d expected=12", st_hs); end
        HRESETn = 1'b0;
        #1;
        checks++; if (hsync !== 1'b0) begin failures++; $display("FAIL async_reset_hsync actual=%b expected=0", hsync); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL async_reset_done_busy done=%b busy=%b expected=0 0", done, busy); end
        checks++; if (mem_rd_en !== 1'b0 || mem_addr !== 16'h0) begin failures++; $display("FAIL async_reset_mem rd_en=%b addr=%h expected=0 0000", mem_rd_en, mem_addr); end
        checks++; if (dout !== 48'h0) begin failures++; $display("FAIL async_reset_data actual=%h expected=000000000000", dout); end
        checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL async_reset_frame_count actual=%0d expected=0", frame_count); end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        saw_activity = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge HCLK);
            if (done !== 1'b0 || busy !== 1'b0 || hsync !== 1'b0) saw_activity = 1'b1;
        end
        checks++; if (saw_activity) begin failures++; $display("FAIL post_reset_quiet actual=active expected=idle"); end
        run_frame(-1, -1);
        checks++; if (st_fetches != TOTAL || st_addr_errs != 0) begin failures++; $display("FAIL replay_addr_sequence fetches=%0d errors=%0d expected=%0d 0", st_fetches, st_addr_errs, TOTAL); end
        checks++; if (st_hs != TOTAL || st_done_edge != EXP_DONE_EDGE) begin failures++; $display("FAIL replay_frame hsync=%0d done_edge=%0d expected=%0d %0d", st_hs, st_done_edge, TOTAL, EXP_DONE_EDGE); end
        checks++; if (frame_count !== 8'd1) begin failures++; $display("FAIL replay_frame_count actual=%0d expected=1", frame_count); end
    endtask

    task automatic test_back_to_back;
        int         cyc, frames, hs, last_done;
        logic [7:0] exp_fc;
        cyc = 0; frames = 0; hs = 0; last_done = -1;
        exp_fc = 8'd1;
        @(negedge HCLK); start = 1'b1;
        while (frames < 256 && cyc < 256 * FRAME_PERIOD + 200) begin
            @(negedge HCLK); cyc++;
            if (hsync === 1'b1) hs++;
            if (done === 1'b1) begin
                checks++; if (hs != TOTAL) begin failures++; $display("FAIL b2b_hsync_count frame=%0d actual=%0d expected=%0d", frames, hs, TOTAL); end
                if (last_done >= 0) begin
                    checks++; if (cyc - last_done != FRAME_PERIOD) begin failures++; $display("FAIL b2b_frame_period frame=%0d actual=%0d expected=%0d", frames, cyc - last_done, FRAME_PERIOD); end
                end
                last_done = cyc; hs = 0; frames++;
                exp_fc = exp_fc + 8'd1;
                @(negedge HCLK); cyc++;
                checks++; if (frame_count !== exp_fc) begin failures++; $display("FAIL b2b_frame_count frame=%0d actual=%0d expected=%0d", frames, frame_count, exp_fc); end
            end
        end
        start = 1'b0;
        checks++; if (frames != 256) begin failures++; $display("FAIL b2b_frames_completed actual=%0d expected=256", frames); end
        checks++; if (frame_count !== 8'd1) begin failures++; $display("FAIL b2b_final_frame_count actual=%0d expected=1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_nominal_frame();
        test_datapath();
        test_stall();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/pixel_pair_sequencer.md
PIXEL_PAIR_SEQUENCER -- requirements
Module: pixel_pair_sequencer

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- WIDTH, 8, image width in pixels (even, ≥ 2).
- HEIGHT, 8, image height in rows (≥ 1).
- LINE_GAP, 2, blanking cycles inserted after each row (≥ 1).

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- HCLK, in, 1, the single clock; all state changes on its rising edge.
- HRESETn, in, 1, asynchronous active-low reset.
- start, in, 1, frame-start request; sampled only in IDLE.
- stall, in, 1, downstream not ready; holds the fetch.
- mem_rd_en, out, 1, pair-memory read strobe.
- mem_addr, out, 16, pair index being read.
- mem_rdata, in, 48, pair data returned one cycle after mem_rd_en, packed {R0,G0,B0,R1,G1,B1}, with R0 at bits [47:40].
- hsync, out, 1, one-cycle pulse qualifying DATA_WRITE_*.
- DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0, DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1, out, 8 each, registered pixel-pair data.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle end-of-frame pulse.
- frame_count, out, 8, number of completed frames.

Function
REQ-003 The block SHALL derive the constants TOTAL = WIDTH*HEIGHT/2 pairs and ROWP = WIDTH/2 pairs per row.
REQ-004 The block SHALL use the states IDLE, FETCH, WAIT, EMIT, BLANK and DONE.
REQ-005 In IDLE, when start = 1, the block SHALL clear pair_cnt and col_cnt and go to FETCH; start SHALL be ignored in every other state.
REQ-006 In FETCH, the block SHALL drive mem_addr = pair_cnt, drive mem_rd_en = !stall (combinational), and go to WAIT when stall = 0; otherwise it SHALL stay in FETCH indefinitely.
REQ-007 On the edge leaving WAIT, the block SHALL capture mem_rdata into the DATA_WRITE_* registers and enter EMIT.
REQ-008 hsync SHALL be 1 exactly during EMIT cycles, and DATA_WRITE_* SHALL hold their value until the next capture.
REQ-009 In EMIT, the block SHALL increment pair_cnt, and SHALL increment col_cnt modulo ROWP.
REQ-010 From EMIT, the next state SHALL be chosen in this priority order:
- DONE if pair_cnt = TOTAL-1;
- else BLANK if col_cnt = ROWP-1 (subject to REQ-018);
- else FETCH.
REQ-011 In BLANK, the block SHALL count LINE_GAP cycles and then enter FETCH; stall SHALL be ignored during BLANK.
REQ-012 In DONE, the block SHALL assert done for one cycle, increment frame_count (wrapping 255 → 0), and return to IDLE.
REQ-013 A start sampled in the same cycle as DONE SHALL be ignored; a new frame requires start to be high while in IDLE.
REQ-014 Each pair SHALL take 3 cycles (FETCH, WAIT, EMIT) in the absence of stall, and every cycle of stall SHALL add exactly one cycle.
REQ-015 mem_addr SHALL be zero-extended from pair_cnt, and SHALL be 0 outside FETCH.

Reset
REQ-016 While HRESETn = 0, the block SHALL asynchronously force: state IDLE; pair_cnt, col_cnt and the blank counter 0; hsync, done, busy and mem_rd_en 0; DATA_WRITE_* 0; frame_count 0.
REQ-017 A reset asserted mid-frame SHALL abort the frame with no done pulse, and the block SHALL resume only on a new start after reset release.

Configuration
REQ-018 The macro LINE_BLANK_EN SHALL control row blanking:
- when LINE_BLANK_EN is defined, BLANK is entered after every row except the last;
- when it is undefined, BLANK is never entered (EMIT goes to FETCH or DONE) and LINE_GAP is unused.

Verification
REQ-019 Nominal frame, defaults, LINE_BLANK_EN defined: start pulse at edge 0, stall = 0 → 32 hsync pulses at a 3-cycle spacing within each row; a 2-cycle gap after rows 0 to 6; done high 111 cycles after edge 0; frame_count = 1.
REQ-020 Nominal frame with LINE_BLANK_EN undefined → 32 hsync pulses, done 97 cycles after the start edge, mem_addr sequence 0 to 31.
REQ-021 Data path: mem_rdata = {8'h11,8'h22,8'h33,8'h44,8'h55,8'h66} for address 5 → during the sixth hsync, R0 = 11h, G0 = 22h, B0 = 33h, R1 = 44h, G1 = 55h, B1 = 66h.
REQ-022 stall held high for 4 cycles while in FETCH at pair 10 → mem_rd_en stays 0 during those cycles; done is delayed by exactly 4 cycles; no pair is skipped or duplicated.
REQ-023 HRESETn pulsed low after the 12th hsync → all outputs are 0 immediately; no done pulse; the next start replays the frame from address 0.
REQ-024 start held high continuously across 256 frames → start is ignored while busy; frame_count wraps 255 → 0; each frame still produces 32 hsync pulses.
